// File: rtl/wb_stage_pkg.sv
// Shared core types for the writeback stage: register/data types, load
// funct3 encodings, FSM state encoding and the captured load context.
package wb_stage_pkg;

  typedef logic [31:0] data_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic        enable_t;
  typedef logic [2:0]  funct3_t;

  localparam funct3_t F3_LB  = 3'b000;
  localparam funct3_t F3_LH  = 3'b001;
  localparam funct3_t F3_LW  = 3'b010;
  localparam funct3_t F3_LBU = 3'b100;
  localparam funct3_t F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Everything needed to finish a load once the LSU response arrives.
  typedef struct packed {
    reg_addr_t  rd;
    enable_t    wen;
    funct3_t    funct3;
    logic [1:0] addr_lo;
  } load_ctx_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage to WB-stage handshake plus the LSU load-response channel.
//   master : MEM stage / LSU side (drives instruction and response)
//   slave  : wb_stage side (drives mem_ready_o)
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic      mem_valid_i;
  logic      mem_ready_o;
  reg_addr_t mem_rd_i;
  enable_t   mem_wen_i;
  logic      mem_is_load_i;
  funct3_t   mem_funct3_i;
  logic [1:0] mem_addr_lo_i;
  data_t     mem_result_i;
  logic      lsu_rsp_valid_i;
  data_t     lsu_rsp_data_i;

  modport master (
    output mem_valid_i, mem_rd_i, mem_wen_i, mem_is_load_i, mem_funct3_i,
           mem_addr_lo_i, mem_result_i, lsu_rsp_valid_i, lsu_rsp_data_i,
    input  mem_ready_o
  );

  modport slave (
    input  mem_valid_i, mem_rd_i, mem_wen_i, mem_is_load_i, mem_funct3_i,
           mem_addr_lo_i, mem_result_i, lsu_rsp_valid_i, lsu_rsp_data_i,
    output mem_ready_o
  );
endinterface

// File: rtl/wb_stage_load_fmt.sv
// load_fmt: combinational load-data formatter.
//   word_i    : aligned 32-bit memory word
//   funct3_i  : load width/sign encoding
//   addr_lo_i : byte offset within the word
//   data_o    : extracted, sign/zero-extended result
//   illegal_o : funct3 is not a load encoding (data_o = full word)
module load_fmt
  import wb_stage_pkg::*;
(
  input  data_t      word_i,
  input  funct3_t    funct3_i,
  input  logic [1:0] addr_lo_i,
  output data_t      data_o,
  output logic       illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Halfword selection uses only addr_lo[1]; bit 0 is ignored.
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o    = word_i;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0, half_sel};
      F3_LW:   data_o = word_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Non-load results are written back one cycle
// after acceptance; loads park in WAIT_LOAD until the LSU response arrives,
// are formatted by load_fmt, then written back the following cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mif (slave)         : MEM-stage handshake and LSU response channel
//   wen_c/rd_o/rd_data_o: register-file write port (wen_c single-cycle)
//   busy_o/busy_rd_o    : load pending and its destination, for decode stall
//   retire_o            : one-cycle pulse per retired instruction
//   err_o               : sticky protocol error (stray response / bad funct3)
//   instret_o           : retired-instruction count, only with WB_INSTRET_EN
// Optional feature macro: WB_INSTRET_EN
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_stage_if.slave      mif,
  output enable_t        wen_c,
  output reg_addr_t      rd_o,
  output data_t          rd_data_o,
  output logic           busy_o,
  output reg_addr_t      busy_rd_o,
  output logic           retire_o,
`ifdef WB_INSTRET_EN
  output logic [INSTRET_W-1:0] instret_o,
`endif
  output logic           err_o
);

  wb_state_e state_q, state_d;
  load_ctx_t ctx_q;

  logic      accept;
  logic      wb_fire;
  enable_t   wb_wen;
  reg_addr_t wb_rd;
  data_t     wb_data;
  logic      err_set;
  data_t     fmt_data;
  logic      fmt_illegal;

  load_fmt u_load_fmt (
    .word_i    (mif.lsu_rsp_data_i),
    .funct3_i  (ctx_q.funct3),
    .addr_lo_i (ctx_q.addr_lo),
    .data_o    (fmt_data),
    .illegal_o (fmt_illegal)
  );

  assign accept = mif.mem_valid_i & (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept && mif.mem_is_load_i) state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: if (mif.lsu_rsp_valid_i)         state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mif.mem_ready_o = (state_q == ST_IDLE);
    busy_o          = (state_q == ST_WAIT_LOAD);
    busy_rd_o       = (state_q == ST_WAIT_LOAD) ? ctx_q.rd : '0;
    wb_fire         = 1'b0;
    wb_wen          = 1'b0;
    wb_rd           = '0;
    wb_data         = '0;
    err_set         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wb_fire = accept & ~mif.mem_is_load_i;
        wb_wen  = mif.mem_wen_i;
        wb_rd   = mif.mem_rd_i;
        wb_data = mif.mem_result_i;
        // A response with no load outstanding is dropped and flagged.
        err_set = mif.lsu_rsp_valid_i;
      end
      ST_WAIT_LOAD: begin
        wb_fire = mif.lsu_rsp_valid_i;
        wb_wen  = ctx_q.wen;
        wb_rd   = ctx_q.rd;
        wb_data = fmt_data;
        err_set = mif.lsu_rsp_valid_i & fmt_illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_q <= '0;
    end else if (accept && mif.mem_is_load_i) begin
      ctx_q <= '{rd: mif.mem_rd_i, wen: mif.mem_wen_i,
                 funct3: mif.mem_funct3_i, addr_lo: mif.mem_addr_lo_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_c     <= 1'b0;
      retire_o  <= 1'b0;
      rd_o      <= '0;
      rd_data_o <= '0;
      err_o     <= 1'b0;
    end else begin
      // x0 writes are suppressed but the instruction still retires.
      wen_c    <= wb_fire & wb_wen & (wb_rd != '0);
      retire_o <= wb_fire;
      if (wb_fire) begin
        rd_o      <= wb_rd;
        rd_data_o <= wb_data;
      end
      if (err_set) err_o <= 1'b1;
    end
  end

`ifdef WB_INSTRET_EN
  // Counts on the same edge retire_o rises, so it already includes that retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       instret_o <= '0;
    else if (wb_fire) instret_o <= instret_o + 1'b1;
  end
`else
  logic unused_instret_w;
  assign unused_instret_w = (INSTRET_W != 0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vectors with a scoreboard. Stimulus pushes
// expected writebacks; a forked monitor pops and compares on each retire.
// Build with +define+WB_INSTRET_EN to also check instret_o.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  enable_t   wen_c;
  reg_addr_t rd_o;
  data_t     rd_data_o;
  logic      busy_o;
  reg_addr_t busy_rd_o;
  logic      retire_o;
  logic      err_o;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
`endif

  wb_stage_if mif ();

  wb_stage #(.INSTRET_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mif       (mif),
    .wen_c     (wen_c),
    .rd_o      (rd_o),
    .rd_data_o (rd_data_o),
    .busy_o    (busy_o),
    .busy_rd_o (busy_rd_o),
    .retire_o  (retire_o),
`ifdef WB_INSTRET_EN
    .instret_o (instret_o),
`endif
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic      wen;
    reg_addr_t rd;
    data_t     data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   run = 0;
  int   max_run = 0;
  int   exp_instret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (rst_n !== 1'b1) return;
    if (retire_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_retire", 64'(retire_o), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_wen", 64'(wen_c), 64'(e.wen));
        if (e.wen) begin
          chk("wb_rd", 64'(rd_o), 64'(e.rd));
          chk("wb_data", 64'(rd_data_o), 64'(e.data));
        end
      end
    end else if (wen_c !== 1'b0) begin
      chk("wen_without_retire", 64'(wen_c), 64'd0);
    end
    if (wen_c === 1'b1) run++;
    else run = 0;
    if (run > max_run) max_run = run;
  endtask

  task automatic expect_wb(input logic wen, input reg_addr_t rd, input data_t data);
    sb.push_back('{wen: wen, rd: rd, data: data});
    exp_instret++;
  endtask

  task automatic idle(input int unsigned n);
    mif.mem_valid_i     = 1'b0;
    mif.lsu_rsp_valid_i = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Presents one non-load for one cycle; caller decides whether valid drops.
  task automatic alu(input reg_addr_t rd, input logic wen, input data_t res, input logic exp_wen);
    mif.mem_valid_i   = 1'b1;
    mif.mem_is_load_i = 1'b0;
    mif.mem_rd_i      = rd;
    mif.mem_wen_i     = wen;
    mif.mem_result_i  = res;
    expect_wb(exp_wen, rd, res);
    @(posedge clk); #1;
  endtask

  task automatic load(input reg_addr_t rd, input funct3_t f3, input logic [1:0] alo,
                      input data_t word, input int unsigned wait_cyc, input data_t exp_data);
    mif.mem_valid_i   = 1'b1;
    mif.mem_is_load_i = 1'b1;
    mif.mem_rd_i      = rd;
    mif.mem_wen_i     = 1'b1;
    mif.mem_funct3_i  = f3;
    mif.mem_addr_lo_i = alo;
    expect_wb(1'b1, rd, exp_data);
    @(posedge clk); #1;
    mif.mem_valid_i = 1'b0;
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      chk("wait_busy", 64'(busy_o), 64'd1);
      chk("wait_ready", 64'(mif.mem_ready_o), 64'd0);
      chk("wait_busy_rd", 64'(busy_rd_o), 64'(rd));
      @(posedge clk); #1;
    end
    mif.lsu_rsp_valid_i = 1'b1;
    mif.lsu_rsp_data_i  = word;
    @(posedge clk); #1;
    mif.lsu_rsp_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    mif.mem_valid_i     = 1'b0;
    mif.mem_rd_i        = '0;
    mif.mem_wen_i       = 1'b0;
    mif.mem_is_load_i   = 1'b0;
    mif.mem_funct3_i    = '0;
    mif.mem_addr_lo_i   = '0;
    mif.mem_result_i    = '0;
    mif.lsu_rsp_valid_i = 1'b0;
    mif.lsu_rsp_data_i  = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    #3;
    chk("rst_ready", 64'(mif.mem_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_wen", 64'(wen_c), 64'd0);
    chk("rst_retire", 64'(retire_o), 64'd0);
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_data", 64'(rd_data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret_o, 64'd0);
`endif
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    alu(5'd5, 1'b1, 32'h0000_1234, 1'b1);
`ifdef WB_INSTRET_EN
    chk("instret_add", instret_o, 64'd1);
`endif
    idle(1);

    load(5'd9,  F3_LB,  2'd3, 32'h80FF_FFFF, 4, 32'hFFFF_FF80);
    load(5'd7,  F3_LHU, 2'd2, 32'h8001_0000, 1, 32'h0000_8001);
    load(5'd8,  F3_LH,  2'd2, 32'h8001_0000, 0, 32'hFFFF_8001);
    load(5'd10, F3_LBU, 2'd1, 32'h0000_1280, 2, 32'h0000_0012);
    load(5'd11, F3_LH,  2'd1, 32'h1234_F00D, 1, 32'hFFFF_F00D);
    load(5'd12, F3_LW,  2'd0, 32'hCAFE_BABE, 3, 32'hCAFE_BABE);
    load(5'd13, F3_LB,  2'd0, 32'h0000_007F, 1, 32'h0000_007F);
    idle(1);

    alu(5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
`ifdef WB_INSTRET_EN
    chk("instret_rd0", instret_o, 64'd9);
`endif
    idle(1);
    alu(5'd3, 1'b0, 32'h0000_0055, 1'b0);
    idle(2);
    chk("err_clean", 64'(err_o), 64'd0);

    for (int unsigned i = 0; i < 10; i++)
      alu(reg_addr_t'(i + 1), 1'b1, 32'h1000_0000 + i, 1'b1);
    idle(3);
    chk("b2b_run", 64'(max_run), 64'd10);
`ifdef WB_INSTRET_EN
    chk("instret_b2b", instret_o, 64'd20);
`endif

    mif.lsu_rsp_valid_i = 1'b1;
    mif.lsu_rsp_data_i  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mif.lsu_rsp_valid_i = 1'b0;
    chk("stray_rsp_err", 64'(err_o), 64'd1);
    idle(2);
    chk("stray_rsp_err_sticky", 64'(err_o), 64'd1);

    // Reset while a load is outstanding: load must vanish without a write.
    mif.mem_valid_i   = 1'b1;
    mif.mem_is_load_i = 1'b1;
    mif.mem_rd_i      = 5'd20;
    mif.mem_wen_i     = 1'b1;
    mif.mem_funct3_i  = F3_LW;
    @(posedge clk); #1;
    mif.mem_valid_i = 1'b0;
    chk("rstwait_busy_before", 64'(busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_busy", 64'(busy_o), 64'd0);
    chk("rstwait_ready", 64'(mif.mem_ready_o), 64'd1);
    chk("rstwait_err", 64'(err_o), 64'd0);
    chk("rstwait_rd", 64'(rd_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
    idle(3);
    chk("rstwait_busy_after", 64'(busy_o), 64'd0);
    chk("rstwait_wen_after", 64'(wen_c), 64'd0);
`ifdef WB_INSTRET_EN
    chk("rstwait_instret", instret_o, 64'd0);
`endif

    load(5'd14, 3'b011, 2'd1, 32'h1234_5678, 1, 32'h1234_5678);
    idle(1);
    chk("illegal_f3_err", 64'(err_o), 64'd1);
`ifdef WB_INSTRET_EN
    chk("instret_final", instret_o, 64'(exp_instret));
`endif

    for (int unsigned i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
